// File: rtl/ghost_hit_monitor.sv
// Latches pixel-exact Yoshi/crazy-ghost overlap over each frame and applies
// damage at the frame boundary: lives, invulnerability blink window, game over.
module ghost_hit_monitor #(
    parameter int LIVES_INIT   = 3,
    parameter int INV_FRAMES   = 120,
    parameter int BLINK_FRAMES = 8,
    parameter int MAX_X        = 640,
    parameter int MAX_Y        = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       yoshi_on,
    input  logic       ghost_crazy_on,
    input  logic       start,
    output logic [1:0] lives,
    output logic       hit,
    output logic       invuln,
    output logic       blink,
    output logic       game_over
);

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        INVULN = 2'd1,
        OVER   = 2'd2
    } state_t;

    localparam logic [9:0] X_LIMIT    = 10'(MAX_X);
    localparam logic [9:0] Y_LIMIT    = 10'(MAX_Y);
    localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [7:0] INV_LOAD   = 8'(INV_FRAMES);
    localparam logic [7:0] BLINK_WRAP = 8'(BLINK_FRAMES);

    state_t     state;
    state_t     state_next;
    logic       y480_reg;
    logic       coll_reg;
    logic [7:0] inv_cnt;
    logic [7:0] blink_cnt;

    logic       frame_tick;
    logic       overlap_vis;
    logic       damage;
    logic [7:0] blink_cnt_inc;

    logic       coll_next;
    logic [1:0] lives_next;
    logic       hit_next;
    logic       blink_next;
    logic [7:0] inv_cnt_next;
    logic [7:0] blink_cnt_next;

    // The first clock with y on the boundary line marks the frame edge, so a
    // y value held for several clocks still yields a single tick.
    assign frame_tick    = (y == Y_LIMIT) && !y480_reg;
    assign overlap_vis   = yoshi_on && ghost_crazy_on && (x < X_LIMIT) && (y < Y_LIMIT);
    assign damage        = (state == PLAY) && frame_tick && coll_reg;
    assign blink_cnt_inc = blink_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PLAY;
            y480_reg  <= 1'b0;
            coll_reg  <= 1'b0;
            inv_cnt   <= 8'd0;
            blink_cnt <= 8'd0;
            lives     <= LIVES_LOAD;
            hit       <= 1'b0;
            invuln    <= 1'b0;
            blink     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_next;
            y480_reg  <= (y == Y_LIMIT);
            coll_reg  <= coll_next;
            inv_cnt   <= inv_cnt_next;
            blink_cnt <= blink_cnt_next;
            lives     <= lives_next;
            hit       <= hit_next;
            invuln    <= (state_next == INVULN);
            blink     <= blink_next;
            game_over <= (state_next == OVER);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PLAY: begin
                if (damage) begin
                    state_next = (lives <= 2'd1) ? OVER : INVULN;
                end
            end
            INVULN: begin
                if (frame_tick && (inv_cnt <= 8'd1)) begin
                    state_next = PLAY;
                end
            end
            OVER: begin
                if (start) begin
                    state_next = PLAY;
                end
            end
            default: state_next = PLAY;
        endcase
    end

    // The latch is evaluated by the FSM on the tick edge and cleared on that
    // same edge; overlap can never coincide with a tick because of the mask.
    always_comb begin
        coll_next      = frame_tick ? 1'b0 : (coll_reg || overlap_vis);
        lives_next     = lives;
        hit_next       = 1'b0;
        blink_next     = blink;
        inv_cnt_next   = inv_cnt;
        blink_cnt_next = blink_cnt;
        case (state)
            PLAY: begin
                if (damage) begin
                    hit_next       = 1'b1;
                    lives_next     = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                    inv_cnt_next   = INV_LOAD;
                    blink_cnt_next = 8'd0;
                    blink_next     = 1'b0;
                end
            end
            INVULN: begin
                if (frame_tick) begin
                    inv_cnt_next = (inv_cnt == 8'd0) ? 8'd0 : inv_cnt - 8'd1;
                    if (inv_cnt <= 8'd1) begin
                        blink_next = 1'b0;
                    end else if (blink_cnt_inc >= BLINK_WRAP) begin
                        blink_cnt_next = 8'd0;
                        blink_next     = !blink;
                    end else begin
                        blink_cnt_next = blink_cnt_inc;
                    end
                end
            end
            OVER: begin
                lives_next = 2'd0;
                if (start) begin
                    lives_next = LIVES_LOAD;
                    coll_next  = 1'b0;
                end
            end
            default: begin
                lives_next = LIVES_LOAD;
            end
        endcase
    end

endmodule

// File: doc/ghost_hit_monitor.md
# ghost_hit_monitor

Downstream consumer of the crazy-ghost sprite block. Watches the per-pixel `ghost_crazy_on` and `yoshi_on` signals during each VGA frame and latches any pixel-exact overlap. At the end of each frame it applies damage to Yoshi: decrements lives, starts an invulnerability window with blink control for Yoshi's renderer, and holds game over until restarted. Its outputs feed the top-level game FSM and the Yoshi sprite and display mux.

## Interface
Parameters:
- `LIVES_INIT`, 3 — lives loaded at reset and on restart (1..3).
- `INV_FRAMES`, 120 — frames of invulnerability after a hit (≥1, ≤255).
- `BLINK_FRAMES`, 8 — frames per blink half-period during invulnerability (≥1, ≤255).
- `MAX_X`, 640 — visible width.
- `MAX_Y`, 480 — visible height.

Ports:
- `clk` in 1 — system clock; one clock; all state on rising edge.
- `reset` in 1 — synchronous, active-high; overrides all other inputs.
- `x` in 10 — current pixel x from vga_sync.
- `y` in 10 — current pixel y from vga_sync.
- `yoshi_on` in 1 — Yoshi sprite opaque at (x,y).
- `ghost_crazy_on` in 1 — crazy ghost opaque at (x,y).
- `start` in 1 — restart request; honoured only in OVER.
- `lives` out 2 — remaining lives.
- `hit` out 1 — one-cycle pulse when damage is applied.
- `invuln` out 1 — high while in INVULN.
- `blink` out 1 — Yoshi hide phase; renderer suppresses Yoshi when high.
- `game_over` out 1 — high in OVER.

## Operation
- **Frame tick.**
  - `y480_reg` is a register holding `(y == MAX_Y)`.
  - `frame_tick = (y == MAX_Y) && !y480_reg`, combinational. It is high exactly one clk per frame.
- **Collision latch `coll_reg`.**
  - Set on any clk where `yoshi_on && ghost_crazy_on && x < MAX_X && y < MAX_Y`.
  - Cleared on the frame_tick edge, after being evaluated.
  - Overlap outside the visible area is ignored.
- **FSM states: PLAY, INVULN, OVER.** Reset state is PLAY.
- **PLAY:**
  - At frame_tick with `coll_reg` = 1: assert `hit`; `lives <= lives - 1`.
  - If lives was 1: go to OVER (lives = 0).
  - Otherwise: go to INVULN with `inv_cnt <= INV_FRAMES`, `blink_cnt <= 0`, `blink <= 0`.
  - At frame_tick with `coll_reg` = 0: no change.
- **INVULN:**
  - Collisions are latched but ignored.
  - At each frame_tick: `inv_cnt` decrements.
  - When `inv_cnt == 1` at frame_tick: go to PLAY with `blink <= 0`.
  - Otherwise `blink_cnt` increments. On reaching BLINK_FRAMES it wraps to 0 and `blink` toggles.
- **OVER:**
  - `lives` = 0, `game_over` = 1; frame_tick has no effect.
  - `start` = 1 on a clk: go to PLAY next edge, `lives <= LIVES_INIT`, `coll_reg <= 0`.
- `start` is ignored in PLAY and INVULN.
- **Widths and arithmetic.**
  - `inv_cnt` and `blink_cnt` are 8 bits.
  - `lives` never underflows; it saturates at 0.

## Timing
- **Reset values:** `lives` = LIVES_INIT, `hit` = 0, `invuln` = 0, `blink` = 0, `game_over` = 0, `coll_reg` = 0, `y480_reg` = 0, state = PLAY.
- **Registered outputs.** All outputs are registered.
  - `hit`, `lives` and the state change all appear on the edge that samples frame_tick.
  - `hit` falls on the following edge.
- **Latency:** pixel overlap to `hit` is at most one frame, plus 1 clk after frame_tick.
- **Simultaneous overlap and frame_tick:** cannot occur, because frame_tick requires y = MAX_Y, which the visible mask excludes.
- **Invulnerability length:** exactly INV_FRAMES frame_ticks, from the entry edge to the PLAY edge.
- **Restart start-up:** after restart, the first possible hit is at the first frame_tick whose frame contained an overlap after the restart edge.
- **Reset mid-operation:** state, counters and the latch return to reset values on the same edge, whatever the state.
- **Input hold:** x and y may hold for several clk per pixel; the latch and tick logic are insensitive to this.

## Test plan
Benches use INV_FRAMES=4 and BLINK_FRAMES=2.

1. **Reset:** assert reset 2 clk → `lives`=3; `hit`, `invuln`, `blink`, `game_over` all 0.
2. **Single hit:** overlap at (100,200) in frame 0 → at frame-0 tick, `hit` 1 clk, `lives`=2, `invuln`=1; `blink` pattern 0,0,1,1 over the next 4 ticks, then `invuln`=0.
3. **Invulnerability masking:** overlap every frame → hits only on ticks 1, 6, 11; `lives` 3→2→1→0; `game_over`=1 after the third hit.
4. **Off-screen mask:** overlap only at y=480 or x=650 → no `hit`, `lives`=3.
5. **Restart:** in OVER, pulse `start` 1 clk → next edge `lives`=3, `game_over`=0. `start` pulsed in PLAY → no change.
6. **Reset mid-INVULN:** reset during INVULN with `inv_cnt`=3 → `invuln`=0, `blink`=0, `lives`=3 on the same edge.
